mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and defaults for the unified-memory port arbiter.
//   - arb_state_t : 3-bit FSM state encoding
//   - XLEN_DEF    : default address/data width
//   - TIMEOUT_DEF : default MemAck wait limit in cycles
package mem_port_arbiter_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_INSTR = 3'd2,
    ST_DRESP = 3'd3,
    ST_IRESP = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory port between instruction fetch and the MEM
//   stage. Data accesses win over fetches. Each access runs
//   grant (IDLE) -> access (DATA/INSTR, waits for MemAck) -> response
//   (DRESP/IRESP), so the minimum latency is 3 cycles. An access that sees
//   no MemAck for TIMEOUT cycles is abandoned: BusErr is set (sticky) and
//   the target register is loaded with 0.
//
//   state  | meaning
//   IDLE   | no access in flight, evaluate grant (data first)
//   DATA   | load/store on the memory port, waiting for MemAck
//   INSTR  | instruction fetch on the memory port, waiting for MemAck
//   DRESP  | load/store complete, MEM stage released this cycle
//   IRESP  | fetch complete, IF stage released this cycle
//
// Ports
//   clk, rst                    clock, async active-high reset
//   IReqF, IAdrF                fetch request / address
//   DReqM, DWeM, DAdrM, DWdataM data request / write enable / address / data
//   MemReq, MemWe, MemAdr,
//   MemWdata, MemRdata, MemAck  shared memory port
//   InstrF, RdataM              registered fetch / load results
//   StallIF, StallMEM           pipeline stall outputs
//   BusErr                      sticky access timeout flag
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            IReqF,
  input  logic [XLEN-1:0] IAdrF,
  input  logic            DReqM,
  input  logic            DWeM,
  input  logic [XLEN-1:0] DAdrM,
  input  logic [XLEN-1:0] DWdataM,
  output logic            MemReq,
  output logic            MemWe,
  output logic [XLEN-1:0] MemAdr,
  output logic [XLEN-1:0] MemWdata,
  input  logic [XLEN-1:0] MemRdata,
  input  logic            MemAck,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] RdataM,
  output logic            StallIF,
  output logic            StallMEM,
  output logic            BusErr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t      state, state_n;
  logic [XLEN-1:0] adr_q, wdata_q;
  logic            we_q;
  logic [CW-1:0]   wait_cnt;
  logic            grant_d, grant_i, in_access, done_ok, done_tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    in_access = 1'b0;
    done_ok   = 1'b0;
    done_tmo  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (DReqM) begin
          grant_d = 1'b1;
          state_n = ST_DATA;
        end else if (IReqF) begin
          grant_i = 1'b1;
          state_n = ST_INSTR;
        end
      end
      ST_DATA, ST_INSTR: begin
        in_access = 1'b1;
        // This cycle is the TIMEOUT-th without an ack when the count is one short.
        if (MemAck)                              done_ok  = 1'b1;
        else if (wait_cnt == CW'(TIMEOUT - 1))   done_tmo = 1'b1;
        if (done_ok || done_tmo)
          state_n = (state == ST_DATA) ? ST_DRESP : ST_IRESP;
      end
      ST_DRESP, ST_IRESP: state_n = ST_IDLE;
      default:            state_n = ST_IDLE;
    endcase
  end

  // Port outputs are gated so they read 0 outside an access and during reset.
  assign MemReq   = in_access;
  assign MemWe    = (state == ST_DATA) && we_q;
  assign MemAdr   = in_access ? adr_q   : '0;
  assign MemWdata = in_access ? wdata_q : '0;

  assign StallMEM = DReqM && (state != ST_DRESP);
  assign StallIF  = StallMEM || (IReqF && (state != ST_IRESP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      InstrF   <= '0;
      RdataM   <= '0;
      BusErr   <= 1'b0;
    end else begin
      if (grant_d) begin
        adr_q   <= DAdrM;
        we_q    <= DWeM;
        wdata_q <= DWdataM;
      end else if (grant_i) begin
        adr_q   <= IAdrF;
        we_q    <= 1'b0;
        wdata_q <= '0;
      end

      if (grant_d || grant_i)       wait_cnt <= '0;
      else if (in_access && !MemAck) wait_cnt <= wait_cnt + 1'b1;

      // Stores have no destination register, so RdataM keeps its value.
      if (state == ST_DATA && !we_q) begin
        if (done_ok)       RdataM <= MemRdata;
        else if (done_tmo) RdataM <= '0;
      end

      if (state == ST_INSTR) begin
        if (done_ok)       InstrF <= MemRdata;
        else if (done_tmo) InstrF <= '0;
      end

      if (done_tmo) BusErr <= 1'b1;
    end
  end

endmodule
